vram_blitter: RTL and testbench

- Bus-master engine that drives one port of the dual-port video RAM: the initiator side of the RAM's synchronous read/write port.
- Performs block fill (constant byte) and block copy (RAM to RAM) on behalf of the extended-register logic, so the CPU does not move bytes one at a time.
- Sits between the extension register file (command source) and VIDEO_RAM port B; port A stays with the raster fetch path.

---
 rtl/vram_blitter.sv | 184 ++++++++++++++++++
 tb/tb_vram_blitter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_blitter.sv
// Block fill / block copy engine mastering the synchronous read/write port B of the video RAM.
// Commands are latched at start; copies alternate read and write cycles because RAM read data arrives one cycle late.
`ifndef VIDEO_RAM_WIDTH
`define VIDEO_RAM_WIDTH 15
`endif

module vram_blitter #(
  parameter int addr_width = `VIDEO_RAM_WIDTH,
  parameter int data_width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  op,
  input  logic                  dir,
  input  logic [addr_width-1:0] src_addr,
  input  logic [addr_width-1:0] dst_addr,
  input  logic [addr_width-1:0] len,
  input  logic [data_width-1:0] fill_val,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_we,
  output logic [addr_width-1:0] ram_addr,
  output logic [data_width-1:0] ram_din,
  input  logic [data_width-1:0] ram_dout
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    CP_RD = 3'd2,
    CP_WR = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [addr_width-1:0] addr_one  = {{(addr_width-1){1'b0}}, 1'b1};
  localparam logic [addr_width-1:0] addr_zero = {addr_width{1'b0}};

  state_t                state_r;
  logic [addr_width-1:0] src_r;
  logic [addr_width-1:0] dst_r;
  logic [addr_width-1:0] rem_r;
  logic [addr_width-1:0] addr_r;
  logic [data_width-1:0] fill_r;
  logic                  dir_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  we_r;
  logic [addr_width-1:0] src_step_s;
  logic [addr_width-1:0] dst_step_s;

  assign busy     = busy_r;
  assign done     = done_r;
  assign ram_we   = we_r;
  assign ram_addr = addr_r;

  // Copy pointers move together in the latched direction.
  always_comb begin
    src_step_s = src_r + addr_one;
    dst_step_s = dst_r + addr_one;
    if (dir_r) begin
      src_step_s = src_r - addr_one;
      dst_step_s = dst_r - addr_one;
    end else begin
      src_step_s = src_r + addr_one;
      dst_step_s = dst_r + addr_one;
    end
  end

  // Copy data is the RAM read result passed straight through to the write port.
  always_comb begin
    ram_din = {data_width{1'b0}};
    case (state_r)
      FILL:    ram_din = fill_r;
      CP_WR:   ram_din = ram_dout;
      default: ram_din = {data_width{1'b0}};
    endcase
  end

  // Sequencer; outputs are loaded for the state being entered so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      src_r   <= addr_zero;
      dst_r   <= addr_zero;
      rem_r   <= addr_zero;
      addr_r  <= addr_zero;
      fill_r  <= {data_width{1'b0}};
      dir_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      we_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          we_r   <= 1'b0;
          busy_r <= 1'b0;
          if (start) begin
            src_r  <= src_addr;
            dst_r  <= dst_addr;
            rem_r  <= len;
            fill_r <= fill_val;
            dir_r  <= dir;
            if (len == addr_zero) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end else if (!op) begin
              state_r <= FILL;
              busy_r  <= 1'b1;
              we_r    <= 1'b1;
              addr_r  <= dst_addr;
            end else begin
              state_r <= CP_RD;
              busy_r  <= 1'b1;
              addr_r  <= src_addr;
            end
          end
        end
        FILL: begin
          if (abort) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            we_r    <= 1'b0;
          end else begin
            dst_r <= dst_r + addr_one;
            rem_r <= rem_r - addr_one;
            if (rem_r == addr_one) begin
              state_r <= DONE;
              busy_r  <= 1'b0;
              we_r    <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              addr_r <= dst_r + addr_one;
            end
          end
        end
        CP_RD: begin
          if (abort) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            state_r <= CP_WR;
            we_r    <= 1'b1;
            addr_r  <= dst_r;
          end
        end
        CP_WR: begin
          we_r <= 1'b0;
          if (abort) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            src_r <= src_step_s;
            dst_r <= dst_step_s;
            rem_r <= rem_r - addr_one;
            if (rem_r == addr_one) begin
              state_r <= DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              state_r <= CP_RD;
              addr_r  <= src_step_s;
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          we_r    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          we_r    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vram_blitter.sv
// Self-checking bench for vram_blitter: a RAM model on port B plus a byte-level reference of fill/copy results.
module tb_vram_blitter;
  localparam int AW    = 15;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, op = 1'b0, dir = 1'b0, abort = 1'b0;
  logic [AW-1:0] src_addr = '0, dst_addr = '0, len = '0;
  logic [7:0]    fill_val = 8'h00;
  logic          busy, done, ram_we;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_din, ram_dout;

  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [7:0]    bd_data = 8'h00;
  logic [7:0]    mem     [DEPTH] = '{default: 8'h00};
  logic [7:0]    ref_mem [DEPTH] = '{default: 8'h00};

  int checks = 0, errors = 0;

  int            obs_cyc_q[$], exp_cyc_q[$];
  logic [AW-1:0] obs_addr_q[$], exp_addr_q[$];
  logic [7:0]    obs_data_q[$], exp_data_q[$];
  int busy_cnt, done_cnt, done_idx, rst_cyc;
  logic pr_busy, pr_done, pr_we;
  logic [AW-1:0] pr_addr;

  always #5 clk = ~clk;

  vram_blitter #(.addr_width(AW), .data_width(8)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .dir(dir),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_val(fill_val),
    .abort(abort), .busy(busy), .done(done), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // RAM model: synchronous write, registered read, plus a backdoor for preloading
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    else if (bd_we) mem[bd_addr] <= bd_data;
    ram_dout <= mem[ram_addr];
  end

  // Reference: apply the first max_wr bytes of a command byte by byte, in transfer order.
  task automatic model_cmd(input bit o, input bit d, input logic [AW-1:0] s, input logic [AW-1:0] dd,
                           input int n, input int max_wr);
    logic [AW-1:0] sa, da;
    logic [7:0] v;
    exp_cyc_q.delete(); exp_addr_q.delete(); exp_data_q.delete();
    for (int k = 0; k < n && k < max_wr; k++) begin
      if (!o) begin
        da = dd + AW'(k);
        v  = fill_val;
        exp_cyc_q.push_back(k + 1);
      end else begin
        sa = d ? s - AW'(k) : s + AW'(k);
        da = d ? dd - AW'(k) : dd + AW'(k);
        v  = ref_mem[sa];
        exp_cyc_q.push_back(2 * (k + 1));
      end
      ref_mem[da] = v;
      exp_addr_q.push_back(da);
      exp_data_q.push_back(v);
    end
  endtask

  task automatic preload(input logic [AW-1:0] base, input int n, input bit rnd, input logic [7:0] first);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      bd_we   = 1'b1;
      bd_addr = base + AW'(k);
      bd_data = rnd ? 8'($urandom) : first + 8'(k * 17);
      ref_mem[bd_addr] = bd_data;
    end
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // Issue one command and observe a fixed number of cycles; optional abort/reset/restart injection.
  task automatic run_cmd(input bit o, input bit d, input logic [AW-1:0] s, input logic [AW-1:0] dd,
                         input logic [AW-1:0] n, input logic [7:0] fv, input int cycles,
                         input int abort_wr, input int rst_wr, input int restart_cyc);
    int wr;
    obs_cyc_q.delete(); obs_addr_q.delete(); obs_data_q.delete();
    busy_cnt = 0; done_cnt = 0; done_idx = 0; rst_cyc = 0; wr = 0;
    pr_busy = 1'b1; pr_done = 1'b1; pr_we = 1'b1; pr_addr = '1;
    @(negedge clk);
    op = o; dir = d; src_addr = s; dst_addr = dd; len = n; fill_val = fv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op = 1'($urandom); dir = 1'($urandom); src_addr = AW'($urandom); dst_addr = AW'($urandom);
    len = AW'($urandom); fill_val = 8'($urandom);
    for (int c = 1; c <= cycles; c++) begin
      abort = 1'b0; rst = 1'b0; start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_idx = c; end
      if (rst_cyc != 0 && c == rst_cyc + 1) begin
        pr_busy = busy; pr_done = done; pr_we = ram_we; pr_addr = ram_addr;
      end
      if (ram_we) begin
        wr++;
        obs_cyc_q.push_back(c); obs_addr_q.push_back(ram_addr); obs_data_q.push_back(ram_din);
        if (wr == abort_wr) abort = 1'b1;
        if (wr == rst_wr) begin rst = 1'b1; rst_cyc = c; end
      end
      if (c == restart_cyc) begin
        start = 1'b1; op = 1'b0; len = AW'($urandom_range(1, 40)); dst_addr = AW'($urandom);
      end
      @(negedge clk);
    end
    abort = 1'b0; rst = 1'b0; start = 1'b0;
  endtask

  function automatic int wr_diff();
    if (obs_addr_q.size() != exp_addr_q.size()) return -2;
    foreach (exp_addr_q[i])
      if (obs_addr_q[i] !== exp_addr_q[i] || obs_data_q[i] !== exp_data_q[i] || obs_cyc_q[i] != exp_cyc_q[i])
        return i;
    return -1;
  endfunction

  function automatic int mem_diff();
    for (int a = 0; a < DEPTH; a++)
      if (mem[a] !== ref_mem[a]) return a;
    return -1;
  endfunction

  task automatic check_run(input string name, input int exp_busy, input int exp_done_cnt, input int exp_done_idx);
    int wd, md;
    wd = wr_diff();
    checks++;
    if (wd != -1) begin
      errors++;
      $display("FAIL %s writes: first bad entry %0d (got %0d writes, required %0d)", name, wd,
               obs_addr_q.size(), exp_addr_q.size());
    end
    checks++;
    if (busy_cnt != exp_busy) begin
      errors++; $display("FAIL %s busy_cycles: got %0d required %0d", name, busy_cnt, exp_busy);
    end
    checks++;
    if (done_cnt != exp_done_cnt || done_idx != exp_done_idx) begin
      errors++;
      $display("FAIL %s done: got %0d pulses at cycle %0d required %0d at cycle %0d", name, done_cnt,
               done_idx, exp_done_cnt, exp_done_idx);
    end
    md = mem_diff();
    checks++;
    if (md != -1) begin
      errors++;
      $display("FAIL %s ram: addr 0x%0h got 0x%0h required 0x%0h", name, md, mem[md], ref_mem[md]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, ram_we} !== 3'b000 || ram_addr !== '0 || ram_din !== 8'h00) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b we=%b addr=0x%0h din=0x%0h required all zero",
               busy, done, ram_we, ram_addr, ram_din);
    end
    rst = 1'b0;
  endtask

  task automatic test_fill_wrap();
    fill_val = 8'hA5;
    model_cmd(1'b0, 1'b0, '0, AW'(15'h7FFE), 4, 4);
    run_cmd(1'b0, 1'b0, '0, AW'(15'h7FFE), AW'(4), 8'hA5, 8, 0, 0, 0);
    check_run("fill_wrap", 4, 1, 5);
  endtask

  task automatic test_copy_asc();
    preload(AW'(15'h0100), 3, 1'b0, 8'h11);
    model_cmd(1'b1, 1'b0, AW'(15'h0100), AW'(15'h0200), 3, 3);
    run_cmd(1'b1, 1'b0, AW'(15'h0100), AW'(15'h0200), AW'(3), 8'h00, 10, 0, 0, 0);
    check_run("copy_asc", 6, 1, 7);
    checks++;
    if (mem[15'h0200] !== 8'h11 || mem[15'h0201] !== 8'h22 || mem[15'h0202] !== 8'h33) begin
      errors++;
      $display("FAIL copy_asc_bytes: got %h %h %h required 11 22 33", mem[15'h0200], mem[15'h0201], mem[15'h0202]);
    end
  endtask

  task automatic test_copy_overlap_desc();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bd_we = 1'b1; bd_addr = AW'(16 + k); bd_data = 8'(k + 1); ref_mem[bd_addr] = bd_data;
    end
    @(negedge clk);
    bd_we = 1'b0;
    model_cmd(1'b1, 1'b1, AW'(15'h13), AW'(15'h14), 4, 4);
    run_cmd(1'b1, 1'b1, AW'(15'h13), AW'(15'h14), AW'(4), 8'h00, 12, 0, 0, 0);
    check_run("copy_overlap_desc", 8, 1, 9);
    checks++;
    if (mem[15'h11] !== 8'd1 || mem[15'h12] !== 8'd2 || mem[15'h13] !== 8'd3 || mem[15'h14] !== 8'd4) begin
      errors++;
      $display("FAIL overlap_bytes: got %0d %0d %0d %0d required 1 2 3 4", mem[15'h11], mem[15'h12],
               mem[15'h13], mem[15'h14]);
    end
  endtask

  task automatic test_zero_len();
    model_cmd(1'b0, 1'b0, '0, AW'(15'h0300), 0, 0);
    run_cmd(1'b0, 1'b0, '0, AW'(15'h0300), AW'(0), 8'h5A, 5, 0, 0, 0);
    check_run("zero_len", 0, 1, 1);
  endtask

  task automatic test_abort();
    fill_val = 8'h3C;
    model_cmd(1'b0, 1'b0, '0, AW'(15'h0400), 10, 3);
    run_cmd(1'b0, 1'b0, '0, AW'(15'h0400), AW'(10), 8'h3C, 14, 3, 0, 0);
    check_run("abort_fill", 3, 0, 0);
  endtask

  task automatic test_ignored_start();
    fill_val = 8'h77;
    model_cmd(1'b0, 1'b0, '0, AW'(15'h0500), 8, 8);
    run_cmd(1'b0, 1'b0, '0, AW'(15'h0500), AW'(8), 8'h77, 14, 0, 0, 3);
    check_run("start_mid_fill", 8, 1, 9);
    fill_val = 8'h88;
    model_cmd(1'b0, 1'b0, '0, AW'(15'h0600), 3, 3);
    run_cmd(1'b0, 1'b0, '0, AW'(15'h0600), AW'(3), 8'h88, 10, 0, 0, 4);
    check_run("start_in_done", 3, 1, 4);
  endtask

  task automatic test_reset_mid_copy();
    preload(AW'(15'h0700), 5, 1'b1, 8'h00);
    model_cmd(1'b1, 1'b0, AW'(15'h0700), AW'(15'h0710), 5, 2);
    run_cmd(1'b1, 1'b0, AW'(15'h0700), AW'(15'h0710), AW'(5), 8'h00, 14, 0, 2, 0);
    check_run("reset_mid_copy", 4, 0, 0);
    checks++;
    if ({pr_busy, pr_done, pr_we} !== 3'b000 || pr_addr !== '0) begin
      errors++;
      $display("FAIL post_reset: busy=%b done=%b we=%b addr=0x%0h required 0 0 0 0x0", pr_busy, pr_done, pr_we, pr_addr);
    end
    fill_val = 8'hC3;
    model_cmd(1'b0, 1'b0, '0, AW'(15'h0720), 5, 5);
    run_cmd(1'b0, 1'b0, '0, AW'(15'h0720), AW'(5), 8'hC3, 9, 0, 0, 0);
    check_run("fill_after_reset", 5, 1, 6);
  endtask

  task automatic test_random();
    logic [AW-1:0] base, s, dd;
    int n;
    bit d;
    for (int it = 0; it < 12; it++) begin
      base = AW'($urandom);
      n    = $urandom_range(1, 20);
      d    = 1'($urandom);
      if (it % 3 == 0) begin
        fill_val = 8'($urandom);
        model_cmd(1'b0, 1'b0, '0, base, n, n);
        run_cmd(1'b0, 1'b0, '0, base, AW'(n), fill_val, n + 4, 0, 0, 0);
        check_run("rand_fill", n, 1, n + 1);
      end else begin
        preload(base, n, 1'b1, 8'h00);
        s  = d ? base + AW'(n - 1) : base;
        dd = s + AW'($urandom_range(0, 16)) - AW'(8);
        model_cmd(1'b1, d, s, dd, n, n);
        run_cmd(1'b1, d, s, dd, AW'(n), 8'h00, 2 * n + 4, 0, 0, 0);
        check_run("rand_copy", 2 * n, 1, 2 * n + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_wrap();
    test_copy_asc();
    test_copy_overlap_desc();
    test_zero_len();
    test_abort();
    test_ignored_start();
    test_reset_mid_copy();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
